e203_exu_alu_issue_buf: RTL
===========================

Name: e203_exu_alu_issue_buf

Overview:
- Dispatch-side initiator for the regular-ALU handshake. It accepts decoded ALU ops from dispatch and buffers them in a 2-entry elastic FIFO.
- It drives alu_i_valid/alu_i_* into the regular ALU unit and consumes alu_i_ready.
- It also enforces WFI serialization: after a WFI op issues, further issue is blocked until a wake pulse arrives. A flush input squashes everything buffered.

Parameters:
- XLEN, 32, operand width (matches E203_XLEN)
- PC_SIZE, 32, PC width (matches E203_PC_SIZE)
- INFO_W, 21, ALU decode-info width (matches E203_DECINFO_ALU_WIDTH)
- WFI_BIT, 20, bit index of the WFI flag inside info (matches E203_DECINFO_ALU_WFI)

Ports:
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  reset, synchronous, active-low
- disp_i_valid  in  1  dispatch offers an op
- disp_i_ready  out  1  buffer accepts the op
- disp_i_rs1  in  XLEN  operand rs1
- disp_i_rs2  in  XLEN  operand rs2
- disp_i_imm  in  XLEN  immediate
- disp_i_pc  in  PC_SIZE  instruction PC
- disp_i_info  in  INFO_W  ALU decode info
- alu_i_valid  out  1  op presented to the regular ALU
- alu_i_ready  in  1  regular ALU accepts
- alu_i_rs1  out  XLEN  head-entry rs1
- alu_i_rs2  out  XLEN  head-entry rs2
- alu_i_imm  out  XLEN  head-entry imm
- alu_i_pc  out  PC_SIZE  head-entry PC
- alu_i_info  out  INFO_W  head-entry info
- flush_req  in  1  pipeline flush; squash all buffered ops
- wfi_wake  in  1  single-cycle pulse; release WFI hold
- wfi_hold  out  1  high while in WFI_WAIT
- buf_cnt  out  2  occupancy, 0..2

Behaviour:
- Reset (rst_n=0 sampled at edge):
  - cnt=0, rd_ptr=0, wr_ptr=0, state=RUN.
  - Payload registers cleared to 0.
  - Resulting outputs: alu_i_valid=0, disp_i_ready=1, wfi_hold=0, buf_cnt=0, all alu_i_* data=0.
  - Reset mid-operation discards all entries and any WFI hold.
- Storage:
  - 2 entries, each {rs1, rs2, imm, pc, info}.
  - rd_ptr and wr_ptr are 1 bit each and wrap 1->0.
- Enqueue:
  - enq = disp_i_valid & disp_i_ready & ~flush_req.
  - disp_i_ready = (cnt!=2) | flush_req. It depends only on registered cnt and flush, with no combinational path from alu_i_ready.
- Dequeue:
  - alu_i_valid = (cnt!=0) & (state==RUN) & ~flush_req.
  - deq = alu_i_valid & alu_i_ready.
  - alu_i_* are driven combinationally from entry[rd_ptr].
- Latency and throughput:
  - An op accepted at edge N is visible on alu_i_* in cycle N+1. There is no bypass.
  - Sustained throughput is one op per cycle.
- Counter update:
  - cnt_next = cnt + enq - deq.
  - Simultaneous enq and deq at cnt=1 leaves cnt=1 and advances both pointers.
  - enq at cnt=2 is impossible (ready=0). deq at cnt=0 is impossible (valid=0).
- Flush:
  - Next state: cnt=0, rd_ptr=wr_ptr=0, state=RUN.
  - During the flush cycle: alu_i_valid=0, and the dispatch op is dropped even though disp_i_ready=1.
  - Flush overrides enq, deq and wfi_wake.
- FSM:
  - RUN -> WFI_WAIT when deq and alu_i_info[WFI_BIT]=1. The WFI op itself issues.
  - WFI_WAIT -> RUN on wfi_wake or flush_req.
  - In WFI_WAIT: alu_i_valid=0; enqueue continues until full; wfi_hold=1.
  - wfi_wake in RUN is ignored.
  - wfi_wake and a same-cycle WFI deq: the FSM still enters WFI_WAIT (the wake belongs to an earlier WFI).
- buf_cnt = cnt, registered.

Decomposition:
- Package e203_alu_issue_pkg holds:
  - typedef alu_issue_entry_t {rs1, rs2, imm, pc, info}
  - enum issue_state_e {RUN, WFI_WAIT}
  - localparams DEPTH=2, PTR_W=1
- Sub-module e203_exu_alu_issue_fifo: generic 2-entry registered FIFO with flush, cnt and pointers.
- The top module adds the valid gating and the WFI FSM.

Test Plan:
- Reset, then 1 op (rs1=0x5, info=ADD) with alu_i_ready=1:
  - alu_i_valid=1 exactly one cycle after accept, alu_i_rs1=0x5.
  - buf_cnt returns to 0.
- Back-to-back, 4 ops with alu_i_ready=0:
  - buf_cnt=2 and disp_i_ready=0 after 2 accepts.
  - Raise ready: ops issue in order 1,2 on consecutive cycles, then 3,4.
- Streaming with ready=1 and valid=1 for 10 cycles:
  - 10 ops issue with one-cycle latency, buf_cnt stays 1.
  - Verifies simultaneous enq+deq and pointer wrap.
- WFI op followed by an ADD:
  - WFI issues; wfi_hold=1; ADD waits with alu_i_valid=0 for 5 cycles.
  - wfi_wake pulse: ADD issues the next cycle, wfi_hold=0.
- flush_req with buf_cnt=2 and disp_i_valid=1, in WFI_WAIT:
  - In the flush cycle alu_i_valid=0.
  - Next cycle: buf_cnt=0, wfi_hold=0, and the dispatch op is not enqueued.
- rst_n=0 asserted with buf_cnt=2:
  - At the next edge all outputs return to reset values: alu_i_valid=0, disp_i_ready=1.

Source files
------------

// File: rtl/e203_exu_alu_issue_buf_pkg.sv
// Shared types and sizing for the regular-ALU issue buffer.
package e203_alu_issue_pkg;

    localparam int E203_XLEN              = 32;
    localparam int E203_PC_SIZE           = 32;
    localparam int E203_DECINFO_ALU_WIDTH = 21;
    localparam int E203_DECINFO_ALU_WFI   = 20;

    localparam int DEPTH = 2;
    localparam int PTR_W = 1;
    localparam int CNT_W = 2;   // holds 0..DEPTH

    typedef struct packed {
        logic [E203_XLEN-1:0]              rs1;
        logic [E203_XLEN-1:0]              rs2;
        logic [E203_XLEN-1:0]              imm;
        logic [E203_PC_SIZE-1:0]           pc;
        logic [E203_DECINFO_ALU_WIDTH-1:0] info;
    } alu_issue_entry_t;

    typedef enum logic {
        RUN      = 1'b0,
        WFI_WAIT = 1'b1
    } issue_state_e;

endpackage

// File: rtl/e203_exu_alu_issue_buf_if.sv
// Dispatch-in / ALU-out handshake bundle for the issue buffer.
// master = environment (dispatch + ALU + control), slave = the buffer.
interface e203_exu_alu_issue_buf_if
    import e203_alu_issue_pkg::*;
#(
    parameter int XLEN    = E203_XLEN,
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int INFO_W  = E203_DECINFO_ALU_WIDTH
);
    logic               disp_i_valid;
    logic               disp_i_ready;
    logic [XLEN-1:0]    disp_i_rs1;
    logic [XLEN-1:0]    disp_i_rs2;
    logic [XLEN-1:0]    disp_i_imm;
    logic [PC_SIZE-1:0] disp_i_pc;
    logic [INFO_W-1:0]  disp_i_info;

    logic               alu_i_valid;
    logic               alu_i_ready;
    logic [XLEN-1:0]    alu_i_rs1;
    logic [XLEN-1:0]    alu_i_rs2;
    logic [XLEN-1:0]    alu_i_imm;
    logic [PC_SIZE-1:0] alu_i_pc;
    logic [INFO_W-1:0]  alu_i_info;

    logic               flush_req;
    logic               wfi_wake;
    logic               wfi_hold;
    logic [CNT_W-1:0]   buf_cnt;

    modport master (
        output disp_i_valid, disp_i_rs1, disp_i_rs2, disp_i_imm, disp_i_pc, disp_i_info,
        output alu_i_ready, flush_req, wfi_wake,
        input  disp_i_ready, alu_i_valid, alu_i_rs1, alu_i_rs2, alu_i_imm, alu_i_pc,
        input  alu_i_info, wfi_hold, buf_cnt
    );

    modport slave (
        input  disp_i_valid, disp_i_rs1, disp_i_rs2, disp_i_imm, disp_i_pc, disp_i_info,
        input  alu_i_ready, flush_req, wfi_wake,
        output disp_i_ready, alu_i_valid, alu_i_rs1, alu_i_rs2, alu_i_imm, alu_i_pc,
        output alu_i_info, wfi_hold, buf_cnt
    );

endinterface

// File: rtl/e203_exu_alu_issue_buf_fifo.sv
// Two-entry registered FIFO with flush. Read data is the head entry,
// driven straight from storage (no write-to-read bypass).
module e203_exu_alu_issue_fifo
    import e203_alu_issue_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_enq,
    input  logic             i_deq,
    input  logic             i_flush,
    input  alu_issue_entry_t i_wdata,
    output alu_issue_entry_t o_rdata,
    output logic [CNT_W-1:0] o_cnt
);

    alu_issue_entry_t r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_cnt;

    // Payload storage: only written on enqueue; flush leaves stale data,
    // which is harmless because the count gates validity.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_enq && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; flush returns everything to the empty state.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (i_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            r_cnt <= r_cnt + CNT_W'(i_enq) - CNT_W'(i_deq);
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/e203_exu_alu_issue_buf.sv
// Regular-ALU issue buffer: 2-deep elastic FIFO between dispatch and the
// ALU, with issue blocked after a WFI op until a wake pulse arrives.
module e203_exu_alu_issue_buf
    import e203_alu_issue_pkg::*;
#(
    parameter int XLEN    = E203_XLEN,
    parameter int PC_SIZE = E203_PC_SIZE,
    parameter int INFO_W  = E203_DECINFO_ALU_WIDTH,
    parameter int WFI_BIT = E203_DECINFO_ALU_WFI
)(
    input  logic clk,
    input  logic rst_n,
    e203_exu_alu_issue_buf_if.slave io
);

    alu_issue_entry_t w_wdata;
    alu_issue_entry_t w_rdata;
    logic [CNT_W-1:0] w_cnt;
    logic             w_disp_rdy;
    logic             w_enq;
    logic             w_deq;
    logic             w_alu_vld;
    logic             w_hold;
    issue_state_e     r_state;
    issue_state_e     w_state_nxt;

    assign w_wdata = '{
        rs1:  io.disp_i_rs1[XLEN-1:0],
        rs2:  io.disp_i_rs2[XLEN-1:0],
        imm:  io.disp_i_imm[XLEN-1:0],
        pc:   io.disp_i_pc[PC_SIZE-1:0],
        info: io.disp_i_info[INFO_W-1:0]
    };

    // Ready depends only on registered count and flush, never on alu_i_ready,
    // so no combinational path exists from the ALU back to dispatch.
    assign w_disp_rdy = (w_cnt != CNT_W'(DEPTH)) | io.flush_req;
    assign w_enq      = io.disp_i_valid & w_disp_rdy & ~io.flush_req;
    assign w_deq      = w_alu_vld & io.alu_i_ready;

    e203_exu_alu_issue_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_enq   (w_enq),
        .i_deq   (w_deq),
        .i_flush (io.flush_req),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata),
        .o_cnt   (w_cnt)
    );

    // WFI FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= RUN;
        else        r_state <= w_state_nxt;
    end

    // WFI FSM next state: a WFI op that issues parks the FSM; wake or flush
    // releases it. A wake coinciding with a WFI issue belongs to an older WFI.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:      if (w_deq && w_rdata.info[WFI_BIT]) w_state_nxt = WFI_WAIT;
            WFI_WAIT: if (io.wfi_wake || io.flush_req)    w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
    end

    // WFI FSM outputs: gate issue while parked or flushing.
    always_comb begin
        w_hold    = (r_state == WFI_WAIT);
        w_alu_vld = (w_cnt != '0) & ~w_hold & ~io.flush_req;
    end

    assign io.disp_i_ready = w_disp_rdy;
    assign io.alu_i_valid  = w_alu_vld;
    assign io.alu_i_rs1    = w_rdata.rs1;
    assign io.alu_i_rs2    = w_rdata.rs2;
    assign io.alu_i_imm    = w_rdata.imm;
    assign io.alu_i_pc     = w_rdata.pc;
    assign io.alu_i_info   = w_rdata.info;
    assign io.wfi_hold     = w_hold;
    assign io.buf_cnt      = w_cnt;

endmodule
